// File: rtl/unidad_de_control_multiciclo.sv
// Multicycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB from the IR opcode,
// stalls on mem_ready and traps on an undefined opcode or a memory wait timeout.
module unidad_de_control_multiciclo #(
  parameter int unsigned ALUOP_W     = 3,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               PcWrite,
  output logic               Branch,
  output logic [1:0]         PcSrc,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemToWrite,
  output logic               IrWrite,
  output logic               MemToReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               AluSrcA,
  output logic [1:0]         AluSrcB,
  output logic [ALUOP_W-1:0] AluOp,
  output logic [3:0]         state_o,
  output logic               illegal_op,
  output logic               mem_timeout
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_FUNCT = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEMADR   = 4'd3,
    MEM_RD   = 4'd4,
    WB_MEM   = 4'd5,
    MEM_WR   = 4'd6,
    EXEC_R   = 4'd7,
    WB_R     = 4'd8,
    EXEC_BEQ = 4'd9,
    EXEC_I   = 4'd10,
    WB_I     = 4'd11,
    EXEC_J   = 4'd12,
    TRAP     = 4'd13
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] waitCnt;
  logic [CNT_W-1:0] waitCntNext;
  logic             illegalNext;
  logic             timeoutNext;
  logic             waitState;
  logic             timeoutHit;

  // Last not-ready cycle allowed before the memory is declared hung
  assign timeoutHit = (MEM_TIMEOUT != 0) && (waitCnt == CNT_W'(MEM_TIMEOUT - 1));
  assign state_o    = state;

  // State, wait counter and sticky trap flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      waitCnt     <= '0;
      illegal_op  <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= stateNext;
      waitCnt     <= waitCntNext;
      illegal_op  <= illegalNext;
      mem_timeout <= timeoutNext;
    end
  end

  // Next state and Moore control decode
  always_comb begin
    PcWrite     = 1'b0;
    Branch      = 1'b0;
    PcSrc       = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemToWrite  = 1'b0;
    IrWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    AluSrcA     = 1'b0;
    AluSrcB     = 2'b00;
    AluOp       = '0;
    stateNext   = state;
    illegalNext = illegal_op;
    timeoutNext = mem_timeout;
    waitState   = 1'b0;

    case (state)
      IDLE: stateNext = FETCH;
      FETCH: begin
        MemRead   = 1'b1;
        AluSrcB   = 2'b01;
        AluOp     = ALUOP_W'(ALU_ADD);
        IrWrite   = mem_ready;
        PcWrite   = mem_ready;
        waitState = 1'b1;
        if (mem_ready) begin
          stateNext = DECODE;
        end else if (timeoutHit) begin
          stateNext   = TRAP;
          timeoutNext = 1'b1;
        end
      end
      DECODE: begin
        AluSrcB = 2'b11;
        AluOp   = ALUOP_W'(ALU_ADD);
        case (op)
          OP_R:                             stateNext = EXEC_R;
          OP_LW, OP_SW:                     stateNext = MEMADR;
          OP_BEQ:                           stateNext = EXEC_BEQ;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: stateNext = EXEC_I;
          OP_J:                             stateNext = EXEC_J;
          default: begin
            stateNext   = TRAP;
            illegalNext = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        AluSrcA   = 1'b1;
        AluSrcB   = 2'b10;
        AluOp     = ALUOP_W'(ALU_ADD);
        stateNext = (op == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        MemRead   = 1'b1;
        IorD      = 1'b1;
        waitState = 1'b1;
        if (mem_ready) begin
          stateNext = WB_MEM;
        end else if (timeoutHit) begin
          stateNext   = TRAP;
          timeoutNext = 1'b1;
        end
      end
      WB_MEM: begin
        MemToReg  = 1'b1;
        RegWrite  = 1'b1;
        stateNext = FETCH;
      end
      MEM_WR: begin
        MemToWrite = 1'b1;
        IorD       = 1'b1;
        waitState  = 1'b1;
        if (mem_ready) begin
          stateNext = FETCH;
        end else if (timeoutHit) begin
          stateNext   = TRAP;
          timeoutNext = 1'b1;
        end
      end
      EXEC_R: begin
        AluSrcA   = 1'b1;
        AluOp     = ALUOP_W'(ALU_FUNCT);
        stateNext = WB_R;
      end
      WB_R: begin
        RegDst    = 1'b1;
        RegWrite  = 1'b1;
        stateNext = FETCH;
      end
      EXEC_BEQ: begin
        AluSrcA   = 1'b1;
        AluOp     = ALUOP_W'(ALU_SUB);
        Branch    = 1'b1;
        PcSrc     = 2'b01;
        stateNext = FETCH;
      end
      EXEC_I: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'b10;
        case (op)
          OP_ANDI: AluOp = ALUOP_W'(ALU_AND);
          OP_ORI:  AluOp = ALUOP_W'(ALU_OR);
          OP_SLTI: AluOp = ALUOP_W'(ALU_SLT);
          default: AluOp = ALUOP_W'(ALU_ADD);
        endcase
        stateNext = WB_I;
      end
      WB_I: begin
        RegWrite  = 1'b1;
        stateNext = FETCH;
      end
      EXEC_J: begin
        PcWrite   = 1'b1;
        PcSrc     = 2'b10;
        stateNext = FETCH;
      end
      TRAP: stateNext = TRAP;
      default: stateNext = IDLE;
    endcase

    // Counter measures consecutive stall cycles within one wait state only
    if (stateNext != state) begin
      waitCntNext = '0;
    end else if (waitState && !mem_ready && (waitCnt != '1)) begin
      waitCntNext = waitCnt + CNT_W'(1);
    end else begin
      waitCntNext = waitCnt;
    end
  end

endmodule

// File: tb/tb_unidad_de_control_multiciclo.sv
// Bench for the multicycle control unit: directed vector table, hand-written corner
// sequences, then random opcode/mem_ready traffic against a phase-queue reference model.
module tb_unidad_de_control_multiciclo;

  localparam int unsigned TIMEOUT = 4;

  typedef enum {
    P_IDLE, P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_WBMEM, P_MEMWR,
    P_EXECR, P_WBR, P_EXECBEQ, P_EXECI, P_WBI, P_EXECJ, P_TRAP
  } phase_t;

  typedef struct packed {
    logic       pcWrite;
    logic       branch;
    logic [1:0] pcSrc;
    logic       iorD;
    logic       memRead;
    logic       memToWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
  } ctrl_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    phase_t     ph;
    logic       ill;
    logic       to;
  } vec_t;

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] ANDI = 6'b001100;
  localparam logic [5:0] ORI  = 6'b001101;
  localparam logic [5:0] SLTI = 6'b001010;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;
  logic       PcWrite, Branch, IorD, MemRead, MemToWrite, IrWrite;
  logic       MemToReg, RegDst, RegWrite, AluSrcA;
  logic [1:0] PcSrc, AluSrcB;
  logic [2:0] AluOp;
  logic [3:0] state_o;
  logic       illegal_op, mem_timeout;
  ctrl_t      actCtrl;

  int total = 0;
  int bad   = 0;

  vec_t   vecs[$];
  phase_t q[$];
  phase_t ph;
  int     waits;
  logic   mIll, mTo;

  unidad_de_control_multiciclo #(
    .ALUOP_W(3), .MEM_TIMEOUT(TIMEOUT), .CNT_W(5)
  ) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .PcWrite(PcWrite), .Branch(Branch), .PcSrc(PcSrc), .IorD(IorD),
    .MemRead(MemRead), .MemToWrite(MemToWrite), .IrWrite(IrWrite),
    .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluOp(AluOp), .state_o(state_o),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  assign actCtrl = {PcWrite, Branch, PcSrc, IorD, MemRead, MemToWrite, IrWrite,
                    MemToReg, RegDst, RegWrite, AluSrcA, AluSrcB, AluOp};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control values each phase must present
  function automatic ctrl_t expOut(phase_t p, logic [5:0] o, logic r);
    ctrl_t c;
    c = '0;
    case (p)
      P_FETCH:   begin c.memRead = 1; c.aluSrcB = 2'b01; c.irWrite = r; c.pcWrite = r; end
      P_DECODE:  c.aluSrcB = 2'b11;
      P_MEMADR:  begin c.aluSrcA = 1; c.aluSrcB = 2'b10; end
      P_MEMRD:   begin c.memRead = 1; c.iorD = 1; end
      P_WBMEM:   begin c.memToReg = 1; c.regWrite = 1; end
      P_MEMWR:   begin c.memToWrite = 1; c.iorD = 1; end
      P_EXECR:   begin c.aluSrcA = 1; c.aluOp = 3'b001; end
      P_WBR:     begin c.regDst = 1; c.regWrite = 1; end
      P_EXECBEQ: begin c.aluSrcA = 1; c.aluOp = 3'b010; c.branch = 1; c.pcSrc = 2'b01; end
      P_EXECI: begin
        c.aluSrcA = 1;
        c.aluSrcB = 2'b10;
        case (o)
          ANDI:    c.aluOp = 3'b100;
          ORI:     c.aluOp = 3'b011;
          SLTI:    c.aluOp = 3'b101;
          default: c.aluOp = 3'b000;
        endcase
      end
      P_WBI:     c.regWrite = 1;
      P_EXECJ:   begin c.pcWrite = 1; c.pcSrc = 2'b10; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  task automatic checkOut(input string name, input phase_t p, input logic [5:0] o,
                          input logic r, input logic il, input logic t);
    ctrl_t e;
    e = expOut(p, o, r);
    total++;
    if (actCtrl !== e) begin
      bad++;
      $display("FAIL %s ctrl phase=%s got=%h want=%h", name, p.name(), actCtrl, e);
    end
    total++;
    if ({illegal_op, mem_timeout} !== {il, t}) begin
      bad++;
      $display("FAIL %s flags phase=%s got=%b%b want=%b%b", name, p.name(),
               illegal_op, mem_timeout, il, t);
    end
    total++;
    if ((state_o === 4'd0) !== (p == P_IDLE)) begin
      bad++;
      $display("FAIL %s idle_state phase=%s state_o=%0d", name, p.name(), state_o);
    end
  endtask

  task automatic applyCycle(input logic r, input logic [5:0] o, input logic d,
                            input phase_t p, input logic il, input logic t, input string name);
    @(negedge clk);
    reset = r; op = o; mem_ready = d;
    #1;
    checkOut(name, p, o, d, il, t);
  endtask

  task automatic addRow(input logic r, input logic [5:0] o, input logic d,
                        input phase_t p, input logic il, input logic t);
    vec_t v;
    v.rst = r; v.op = o; v.rdy = d; v.ph = p; v.ill = il; v.to = t;
    vecs.push_back(v);
  endtask

  // Reference model: an instruction is the list of phases remaining after DECODE
  task automatic modelStep(input logic [5:0] o, input logic r);
    if (ph == P_TRAP) return;
    if ((ph == P_FETCH || ph == P_MEMRD || ph == P_MEMWR) && !r) begin
      waits++;
      if (waits == int'(TIMEOUT)) begin
        ph  = P_TRAP;
        mTo = 1'b1;
      end
      return;
    end
    waits = 0;
    case (ph)
      P_IDLE:  ph = P_FETCH;
      P_FETCH: ph = P_DECODE;
      P_DECODE: begin
        case (o)
          R:                      q = '{P_EXECR, P_WBR};
          LW:                     q = '{P_MEMADR, P_MEMRD, P_WBMEM};
          SW:                     q = '{P_MEMADR, P_MEMWR};
          BEQ:                    q = '{P_EXECBEQ};
          ADDI, ANDI, ORI, SLTI:  q = '{P_EXECI, P_WBI};
          J:                      q = '{P_EXECJ};
          default:                q.delete();
        endcase
        if (q.size() == 0) begin
          ph   = P_TRAP;
          mIll = 1'b1;
        end else begin
          ph = q.pop_front();
        end
      end
      default: ph = (q.size() != 0) ? q.pop_front() : P_FETCH;
    endcase
  endtask

  function automatic logic [5:0] pickOp();
    logic [5:0] legal [9];
    legal = '{R, LW, SW, BEQ, ADDI, ANDI, ORI, SLTI, J};
    if ($urandom_range(0, 7) == 0) return 6'($urandom_range(0, 63));
    return legal[$urandom_range(0, 8)];
  endfunction

  initial begin
    logic       r, d;
    logic [5:0] curOp;
    int         trapCnt;

    reset = 1'b1; op = R; mem_ready = 1'b1;

    // R-type, lw with two stalls, beq, sw with one stall, j, every I-type, timeouts
    addRow(1, R, 1, P_IDLE, 0, 0);     addRow(0, R, 1, P_IDLE, 0, 0);
    addRow(0, R, 1, P_FETCH, 0, 0);    addRow(0, R, 1, P_DECODE, 0, 0);
    addRow(0, R, 1, P_EXECR, 0, 0);    addRow(0, R, 1, P_WBR, 0, 0);
    addRow(0, LW, 1, P_FETCH, 0, 0);   addRow(0, LW, 1, P_DECODE, 0, 0);
    addRow(0, LW, 1, P_MEMADR, 0, 0);  addRow(0, LW, 0, P_MEMRD, 0, 0);
    addRow(0, LW, 0, P_MEMRD, 0, 0);   addRow(0, LW, 1, P_MEMRD, 0, 0);
    addRow(0, LW, 1, P_WBMEM, 0, 0);
    addRow(0, BEQ, 1, P_FETCH, 0, 0);  addRow(0, BEQ, 1, P_DECODE, 0, 0);
    addRow(0, BEQ, 1, P_EXECBEQ, 0, 0);
    addRow(0, SW, 1, P_FETCH, 0, 0);   addRow(0, SW, 1, P_DECODE, 0, 0);
    addRow(0, SW, 1, P_MEMADR, 0, 0);  addRow(0, SW, 0, P_MEMWR, 0, 0);
    addRow(0, SW, 1, P_MEMWR, 0, 0);
    addRow(0, J, 1, P_FETCH, 0, 0);    addRow(0, J, 1, P_DECODE, 0, 0);
    addRow(0, J, 1, P_EXECJ, 0, 0);
    addRow(0, ORI, 1, P_FETCH, 0, 0);  addRow(0, ORI, 1, P_DECODE, 0, 0);
    addRow(0, ORI, 1, P_EXECI, 0, 0);  addRow(0, ORI, 1, P_WBI, 0, 0);
    addRow(0, ADDI, 1, P_FETCH, 0, 0); addRow(0, ADDI, 1, P_DECODE, 0, 0);
    addRow(0, ADDI, 1, P_EXECI, 0, 0); addRow(0, ADDI, 1, P_WBI, 0, 0);
    addRow(0, ANDI, 1, P_FETCH, 0, 0); addRow(0, ANDI, 1, P_DECODE, 0, 0);
    addRow(0, ANDI, 1, P_EXECI, 0, 0); addRow(0, ANDI, 1, P_WBI, 0, 0);
    addRow(0, SLTI, 1, P_FETCH, 0, 0); addRow(0, SLTI, 1, P_DECODE, 0, 0);
    addRow(0, SLTI, 1, P_EXECI, 0, 0); addRow(0, SLTI, 1, P_WBI, 0, 0);
    addRow(0, R, 0, P_FETCH, 0, 0);    addRow(0, R, 0, P_FETCH, 0, 0);
    addRow(0, R, 0, P_FETCH, 0, 0);    addRow(0, R, 0, P_FETCH, 0, 0);
    addRow(0, R, 1, P_TRAP, 0, 1);     addRow(0, R, 1, P_TRAP, 0, 1);
    addRow(1, R, 1, P_IDLE, 0, 0);     addRow(0, R, 0, P_IDLE, 0, 0);
    addRow(0, R, 0, P_FETCH, 0, 0);    addRow(0, R, 0, P_FETCH, 0, 0);
    addRow(0, R, 0, P_FETCH, 0, 0);    addRow(0, R, 1, P_FETCH, 0, 0);
    addRow(0, R, 1, P_DECODE, 0, 0);   addRow(0, R, 1, P_EXECR, 0, 0);
    addRow(0, R, 1, P_WBR, 0, 0);

    foreach (vecs[i])
      applyCycle(vecs[i].rst, vecs[i].op, vecs[i].rdy, vecs[i].ph,
                 vecs[i].ill, vecs[i].to, $sformatf("vec%0d", i));

    // Reset asserted in the middle of a WB_I cycle kills RegWrite immediately
    applyCycle(1, ORI, 1, P_IDLE, 0, 0, "wbi_rst");
    applyCycle(0, ORI, 1, P_IDLE, 0, 0, "wbi_rst");
    applyCycle(0, ORI, 1, P_FETCH, 0, 0, "wbi_rst");
    applyCycle(0, ORI, 1, P_DECODE, 0, 0, "wbi_rst");
    applyCycle(0, ORI, 1, P_EXECI, 0, 0, "wbi_rst");
    applyCycle(0, ORI, 1, P_WBI, 0, 0, "wbi_rst");
    #2 reset = 1'b1;
    #1;
    total++;
    if (actCtrl !== '0 || state_o !== 4'd0) begin
      bad++;
      $display("FAIL rst_mid_wbi ctrl=%h state_o=%0d want 0/0", actCtrl, state_o);
    end
    applyCycle(1, ORI, 1, P_IDLE, 0, 0, "wbi_hold");
    applyCycle(0, ORI, 1, P_IDLE, 0, 0, "wbi_rel");

    // Undefined opcode traps and holds all controls low until reset
    applyCycle(0, BAD, 1, P_FETCH, 0, 0, "ill");
    applyCycle(0, BAD, 1, P_DECODE, 0, 0, "ill");
    for (int i = 0; i < 20; i++)
      applyCycle(0, BAD, 1'($urandom_range(0, 1)), P_TRAP, 1, 0, "ill_hold");
    applyCycle(1, BAD, 1, P_IDLE, 0, 0, "ill_clear");

    // Random traffic against the model
    ph = P_IDLE; q.delete(); waits = 0; mIll = 0; mTo = 0; trapCnt = 0; curOp = R;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      r = (cyc == 0) || (ph == P_TRAP && trapCnt > 3) || ($urandom_range(0, 199) == 0);
      if (r) begin
        ph = P_IDLE; q.delete(); waits = 0; mIll = 0; mTo = 0; trapCnt = 0;
      end
      if (ph == P_IDLE || ph == P_FETCH) curOp = pickOp();
      d = ($urandom_range(0, 2) != 0);
      reset = r; op = curOp; mem_ready = d;
      #1;
      checkOut("rand", ph, curOp, d, mIll, mTo);
      @(posedge clk);
      if (!r) modelStep(curOp, d);
      if (ph == P_TRAP) trapCnt++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
